// File: rtl/pb_pkg.sv
// Shared types and constants for the packet builder: FSM states, header
// field layout, CRC polynomial and the header ECC function.
package pb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_LO,
        ST_HDR_HI,
        ST_PAYLOAD,
        ST_CRC_WR,
        ST_DONE,
        ST_ERR
    } pb_state_t;

    // Header low byte: {byte_cnt, ecc[3:0]}; high byte: {sop, msb, pkt_type}
    localparam int HDR_LO_ECC_LSB  = 0;
    localparam int HDR_LO_CNT_LSB  = 4;
    localparam int HDR_HI_TYPE_LSB = 0;
    localparam int HDR_HI_MSB_BIT  = 4;
    localparam int HDR_HI_SOP_LSB  = 5;

    localparam logic [7:0] INJ_SINGLE_MASK = 8'h10;
    localparam logic [7:0] INJ_DOUBLE_MASK = 8'h30;

    localparam logic [7:0] CRC_POLY = 8'h07;

    // Returns {overall parity, ecc[3:0]} over d = {pkt_type, byte_cnt}
    function automatic logic [4:0] hdr_ecc(input logic [7:0] d);
        logic [3:0] e;
        e[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        e[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        e[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
        e[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return {^d, e};
    endfunction

endpackage

// File: rtl/pb_crc8_step.sv
// One-byte CRC-8 update, MSB-first, no reflection; purely combinational.
module pb_crc8_step
    import pb_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] c;

    always_comb begin
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/pkt_builder_crc8.sv
// Writes one packet (ECC header, payload, CRC-8 trailer) into inmem byte by
// byte, with optional header-ECC and CRC corruption for test traffic.
module pkt_builder_crc8
    import pb_pkg::*;
#(
    parameter int                ADDR_W   = 14,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 14'h12,
    parameter logic [2:0]        SOP_VAL  = 3'b101
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pb_start,
    input  logic [ADDR_W-1:0] pb_addr_hdr,
    input  logic [3:0]        pb_byte_cnt,
    input  logic [3:0]        pb_pkt_type,
    input  logic [1:0]        pb_inj_ecc,
    input  logic              pb_inj_crc,
    output logic              pb_busy,
    output logic              pb_irq,
    output logic              pb_cfg_err,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic [7:0]        src_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata
);

    localparam int EW = ADDR_W + 1;

    pb_state_t         state;
    pb_state_t         state_nxt;

    logic [ADDR_W-1:0] hdr_addr;
    logic [3:0]        byte_cnt;
    logic [3:0]        pkt_type;
    logic [1:0]        inj_ecc;
    logic              inj_crc;

    logic [3:0]        wr_cnt;
    logic [7:0]        crc_acc;
    logic [7:0]        crc_step;

    logic [ADDR_W:0]   last_addr;
    logic              range_bad;
    logic              start_ok;
    logic              pay_xfer;
    logic [4:0]        ecc;
    logic [7:0]        hdr_lo;
    logic [7:0]        hdr_hi;

    // Extra bit keeps the end-of-packet sum from wrapping before the compare
    assign last_addr = EW'(pb_addr_hdr) + EW'(pb_byte_cnt) + EW'(3);
    assign range_bad = last_addr > EW'(MAX_ADDR);
    assign start_ok  = (state == ST_IDLE) && pb_start;
    assign pay_xfer  = (state == ST_PAYLOAD) && src_valid;

    pb_crc8_step u_crc_step (
        .crc_in  (crc_acc),
        .data_in (src_data),
        .crc_out (crc_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            wr_cnt  <= 4'd0;
            crc_acc <= 8'h00;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                wr_cnt  <= 4'd0;
                crc_acc <= 8'h00;
            end else if (pay_xfer) begin
                wr_cnt  <= wr_cnt + 4'd1;
                crc_acc <= crc_step;
            end
        end
    end

    // Packet fields are data only; the FSM gates every use of them
    always_ff @(posedge clk) begin
        if (start_ok) begin
            hdr_addr <= pb_addr_hdr;
            byte_cnt <= pb_byte_cnt;
            pkt_type <= pb_pkt_type;
            inj_ecc  <= pb_inj_ecc;
            inj_crc  <= pb_inj_crc;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pb_start) begin
                    state_nxt = range_bad ? ST_ERR : ST_HDR_LO;
                end
            end
            ST_HDR_LO:  state_nxt = ST_HDR_HI;
            ST_HDR_HI:  state_nxt = ST_PAYLOAD;
            ST_PAYLOAD: begin
                if (src_valid && (wr_cnt == byte_cnt)) begin
                    state_nxt = ST_CRC_WR;
                end
            end
            ST_CRC_WR:  state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            ST_ERR:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // ECC always reflects the true fields; injection only corrupts the stored byte
    always_comb begin
        ecc    = hdr_ecc({pkt_type, byte_cnt});
        hdr_lo = 8'h00;
        hdr_lo[HDR_LO_CNT_LSB +: 4] = byte_cnt;
        hdr_lo[HDR_LO_ECC_LSB +: 4] = ecc[3:0];
        case (inj_ecc)
            2'd1:    hdr_lo = hdr_lo ^ INJ_SINGLE_MASK;
            2'd2:    hdr_lo = hdr_lo ^ INJ_DOUBLE_MASK;
            default: hdr_lo = hdr_lo;
        endcase
        hdr_hi = 8'h00;
        hdr_hi[HDR_HI_TYPE_LSB +: 4] = pkt_type;
        hdr_hi[HDR_HI_MSB_BIT]       = ecc[4];
        hdr_hi[HDR_HI_SOP_LSB +: 3]  = SOP_VAL;
    end

    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 8'h00;
        src_ready  = 1'b0;
        pb_busy    = 1'b0;
        pb_irq     = 1'b0;
        pb_cfg_err = 1'b0;
        case (state)
            ST_HDR_LO: begin
                pb_busy   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = hdr_addr;
                mem_wdata = hdr_lo;
            end
            ST_HDR_HI: begin
                pb_busy   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = hdr_addr + ADDR_W'(1);
                mem_wdata = hdr_hi;
            end
            ST_PAYLOAD: begin
                pb_busy   = 1'b1;
                src_ready = 1'b1;
                mem_we    = src_valid;
                mem_addr  = hdr_addr + ADDR_W'(wr_cnt) + ADDR_W'(2);
                mem_wdata = src_data;
            end
            ST_CRC_WR: begin
                pb_busy   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = hdr_addr + ADDR_W'(byte_cnt) + ADDR_W'(3);
                mem_wdata = crc_acc ^ {7'b0, inj_crc};
            end
            ST_DONE: begin
                pb_busy = 1'b1;
                pb_irq  = 1'b1;
            end
            ST_ERR: begin
                pb_cfg_err = 1'b1;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/pkt_builder_crc8.md
# pkt_builder_crc8

Packet builder that writes complete packets into input memory, byte by byte, in the exact layout the packet parser consumes. Each packet is a two-byte ECC-protected header, then `byte_cnt+1` payload bytes, then one CRC-8 byte. It sits in front of inmem as the writer side of the parser's protocol. Optional error injection lets the bench produce packets with correctable/uncorrectable header errors and bad CRCs on demand.

## Interface
Parameters:
- `ADDR_W`, 14, inmem byte-address width
- `MAX_ADDR`, 14'h12, highest legal packet byte address
- `SOP_VAL`, 3'b101, start-of-packet marker written to header bits [15:13]

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `pb_start`  in  1  start pulse, sampled only in IDLE
- `pb_addr_hdr`  in  ADDR_W  header byte address
- `pb_byte_cnt`  in  4  payload length minus one
- `pb_pkt_type`  in  4  packet type
- `pb_inj_ecc`  in  2  header error injection: 0 none, 1 single-bit, 2 double-bit, 3 reserved (treated as 0)
- `pb_inj_crc`  in  1  corrupt CRC byte
- `pb_busy`  out  1  packet in progress
- `pb_irq`  out  1  one-cycle pulse: packet fully written
- `pb_cfg_err`  out  1  one-cycle pulse: start rejected
- `src_valid`  in  1  payload byte valid
- `src_ready`  out  1  builder accepts payload byte
- `src_data`  in  8  payload byte
- `mem_we`  out  1  byte write enable
- `mem_addr`  out  ADDR_W  byte address
- `mem_wdata`  out  8  byte data

## Operation
- **Start**
  - On `pb_start` in IDLE, latch `pb_addr_hdr`, `pb_byte_cnt`, `pb_pkt_type`, `pb_inj_ecc` and `pb_inj_crc`.
  - Inputs are not re-read mid-packet.
- **Range check**
  - If `addr_hdr + byte_cnt + 3 > MAX_ADDR`, go to ERR: pulse `pb_cfg_err`, make no writes, return to IDLE.
- **ECC**
  - Input is d[7:0] = {pkt_type, byte_cnt}.
  - ecc0 = d0^d1^d3^d4^d6
  - ecc1 = d0^d2^d3^d5^d6
  - ecc2 = d1^d2^d3^d7
  - ecc3 = d4^d5^d6^d7
  - msb = ^d[7:0]
- **Header bytes**
  - Low byte at addr_hdr = {byte_cnt, ecc[3:0]}.
  - High byte at addr_hdr+1 = {SOP_VAL, msb, pkt_type}.
- **Injection**
  - ECC is always computed from the true fields.
  - `inj_ecc`=1 flips low-byte bit 4.
  - `inj_ecc`=2 flips low-byte bits 4 and 5.
  - `inj_crc` XORs the CRC byte with 8'h01.
  - The payload length always uses the true byte_cnt.
- **Payload**
  - `byte_cnt+1` bytes, written at addr_hdr+2 .. addr_hdr+2+byte_cnt.
- **CRC**
  - CRC-8, poly 8'h07, init 8'h00, MSB-first, no reflection, no final XOR.
  - Computed over the payload bytes only.
  - Written at addr_hdr+byte_cnt+3.
- **FSM**: IDLE → HDR_LO → HDR_HI → PAYLOAD → CRC_WR → DONE → IDLE. ERR is reached from IDLE only.
- **Address arithmetic**: ADDR_W bits, no wrap is possible because of the range check.
- **Byte counter**: 4-bit count of bytes written; PAYLOAD exits when count == byte_cnt and a byte is accepted.

## Timing
- **Reset values**: state IDLE; `pb_busy`, `pb_irq`, `pb_cfg_err`, `src_ready` and `mem_we` are 0; `mem_addr` and `mem_wdata` are 0; CRC accumulator is 0.
- **Write port**: `mem_*` are combinational from state registers; one byte is written per `mem_we` cycle.
- **Payload handshake**
  - `src_ready`=1 exactly in PAYLOAD.
  - A transfer happens when `src_valid`&&`src_ready`; `mem_we`=`src_valid` in that cycle.
  - `src_valid` low stalls PAYLOAD: no address or count change.
- **Full throughput** (`src_valid` held high, start in cycle 0):
  - HDR_LO in cycle 1, HDR_HI in cycle 2.
  - Payload in cycles 3 .. 3+byte_cnt.
  - CRC_WR in cycle 4+byte_cnt.
  - `pb_irq` in cycle 5+byte_cnt.
- **Busy**: `pb_busy`=1 from HDR_LO through DONE inclusive.
- **Start while busy**: `pb_start` is ignored. A start in the DONE cycle is also ignored.
- **Config error**: `pb_cfg_err` is asserted in cycle 1; `pb_busy` stays 0.
- **Reset mid-packet**
  - All state clears immediately; the next write is suppressed.
  - Bytes already in memory stay as written.
  - No `pb_irq` is produced for that packet.

## Structure
- **`pb_pkg`**
  - State enum.
  - Header field bit positions.
  - CRC polynomial constant.
  - Function `hdr_ecc(d)` returning {msb, ecc[3:0]}.
- **`pb_crc8_step`**: combinational sub-module; inputs `crc_in`[7:0] and `data_in`[7:0], output `crc_out`[7:0]. It is instantiated once, and its output is registered into the accumulator on each accepted payload byte.

## Test plan
- **Basic packet**: addr_hdr=4, byte_cnt=2, pkt_type=3, payload 01,02,03 with `src_valid` held high → writes [4]=0x26, [5]=0xB3, [6..8]=01,02,03, [9]=0x48; `pb_irq` in cycle 7.
- **Single-bit injection**: same packet with `inj_ecc`=1 → [4]=0x36; all other bytes identical.
- **Double-bit injection**: `inj_ecc`=2 → [4]=0x16. Separately, `inj_crc`=1 → [9]=0x49.
- **Backpressure**: `src_valid` low for 3 cycles before the second byte → no `mem_we`, `mem_addr` held at 7; `pb_irq` delayed by exactly 3 cycles.
- **Range boundary**: addr_hdr=0x10, byte_cnt=3 → `pb_cfg_err` pulse in cycle 1, zero writes, no `pb_irq`. addr_hdr=0xC, byte_cnt=3 (sum 0x12) → accepted, CRC byte written at 0x12.
- **Reset and busy start**: reset asserted in the first payload cycle → no further `mem_we`, all outputs at reset values, and a new start after deassertion runs normally. `pb_start` while busy → ignored, and the current packet is unaltered.
